// File: rtl/spi_target_if.sv
// rtl/spi_target_if.sv - pin and byte-stream bundle for the SPI mode-0 target.
// slave is the target side; master is the controller/system side.
interface spi_target_if;
  logic       spi_sck_i;
  logic       spi_cs_ni;
  logic       spi_copi_i;
  logic       spi_cipo_o;
  logic       spi_cipo_en_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic       rx_overflow_o;
  logic       tx_underflow_o;
  logic       busy_o;

  modport slave (
    input  spi_sck_i, spi_cs_ni, spi_copi_i, rx_ready_i, tx_data_i, tx_valid_i,
    output spi_cipo_o, spi_cipo_en_o, rx_data_o, rx_valid_o, tx_ready_o,
           rx_overflow_o, tx_underflow_o, busy_o
  );

  modport master (
    output spi_sck_i, spi_cs_ni, spi_copi_i, rx_ready_i, tx_data_i, tx_valid_i,
    input  spi_cipo_o, spi_cipo_en_o, rx_data_o, rx_valid_o, tx_ready_o,
           rx_overflow_o, tx_underflow_o, busy_o
  );
endinterface

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target, MSB first, 8-bit frames, pins oversampled by clk_i.
// SPI_TARGET_ECHO_EN: on TX underflow send the last completed RX byte instead of 0xFF.
module spi_target #(
  parameter int SyncStages = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  spi_target_if.slave  bus
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [SyncStages-1:0] sck_sync_q, sck_sync_d;
  logic [SyncStages-1:0] cs_sync_q, cs_sync_d;
  logic [SyncStages-1:0] copi_sync_q, copi_sync_d;
  logic [SyncStages-1:0] fill_q, fill_d;
  logic                  sck_prev_q, sck_prev_d;
  logic                  cs_prev_q, cs_prev_d;
  logic                  armed_q, armed_d;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       cipo_en_q, cipo_en_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       rx_overflow_q, rx_overflow_d;
  logic       tx_underflow_q, tx_underflow_d;

`ifdef SPI_TARGET_ECHO_EN
  logic [7:0] last_rx_q, last_rx_d;
`endif

  logic       sck_s, cs_s, copi_s;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;
  logic       load_req;
  logic [7:0] rx_byte;
  logic [7:0] fill_byte;

  assign sck_s    = sck_sync_q[SyncStages-1];
  assign cs_s     = cs_sync_q[SyncStages-1];
  assign copi_s   = copi_sync_q[SyncStages-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

`ifdef SPI_TARGET_ECHO_EN
  assign fill_byte = last_rx_q;
`else
  assign fill_byte = 8'hFF;
`endif

  always_comb begin
    sck_sync_d     = {sck_sync_q[SyncStages-2:0], bus.spi_sck_i};
    cs_sync_d      = {cs_sync_q[SyncStages-2:0], bus.spi_cs_ni};
    copi_sync_d    = {copi_sync_q[SyncStages-2:0], bus.spi_copi_i};
    fill_d         = {fill_q[SyncStages-2:0], 1'b1};
    sck_prev_d     = sck_s;
    cs_prev_d      = cs_s;
    // A CS low held across reset release must not start a frame: only arm
    // once a genuine post-reset sample of CS high has reached the sync output.
    armed_d        = armed_q | (fill_q[SyncStages-1] & cs_s);
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    cipo_en_d      = cipo_en_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q;
    hold_d         = hold_q;
    hold_full_d    = hold_full_q;
    rx_overflow_d  = 1'b0;
    tx_underflow_d = 1'b0;
    load_req       = 1'b0;
    rx_byte        = {rx_shift_q, copi_s};
`ifdef SPI_TARGET_ECHO_EN
    last_rx_d      = last_rx_q;
`endif

    if (rx_valid_q && bus.rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d   = ACTIVE;
          bit_cnt_d = 3'd0;
          cipo_en_d = 1'b1;
          load_req  = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          cipo_en_d = 1'b0;
        end else begin
          if (sck_rise) begin
            rx_shift_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef SPI_TARGET_ECHO_EN
              last_rx_d = rx_byte;
`endif
              if (rx_valid_q && !bus.rx_ready_i) begin
                rx_overflow_d = 1'b1;
              end else begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
              end
            end
          end
          if (sck_fall) begin
            if (bit_cnt_q != 3'd0) begin
              tx_shift_d = {tx_shift_q[6:0], 1'b1};
            end else begin
              load_req = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_req) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d     = fill_byte;
        tx_underflow_d = 1'b1;
      end
    end

    // Write after the load so a same-cycle load and write leaves it full.
    if (bus.tx_valid_i && !hold_full_q) begin
      hold_d      = bus.tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q     <= '0;
      cs_sync_q      <= '1;
      copi_sync_q    <= '0;
      fill_q         <= '0;
      sck_prev_q     <= 1'b0;
      cs_prev_q      <= 1'b1;
      armed_q        <= 1'b0;
      state_q        <= IDLE;
      bit_cnt_q      <= 3'd0;
      rx_shift_q     <= 7'd0;
      tx_shift_q     <= 8'hFF;
      cipo_en_q      <= 1'b0;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      hold_q         <= 8'h00;
      hold_full_q    <= 1'b0;
      rx_overflow_q  <= 1'b0;
      tx_underflow_q <= 1'b0;
`ifdef SPI_TARGET_ECHO_EN
      last_rx_q      <= 8'hFF;
`endif
    end else begin
      sck_sync_q     <= sck_sync_d;
      cs_sync_q      <= cs_sync_d;
      copi_sync_q    <= copi_sync_d;
      fill_q         <= fill_d;
      sck_prev_q     <= sck_prev_d;
      cs_prev_q      <= cs_prev_d;
      armed_q        <= armed_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      cipo_en_q      <= cipo_en_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      rx_overflow_q  <= rx_overflow_d;
      tx_underflow_q <= tx_underflow_d;
`ifdef SPI_TARGET_ECHO_EN
      last_rx_q      <= last_rx_d;
`endif
    end
  end

  assign bus.spi_cipo_o     = tx_shift_q[7];
  assign bus.spi_cipo_en_o  = cipo_en_q;
  assign bus.rx_data_o      = rx_data_q;
  assign bus.rx_valid_o     = rx_valid_q;
  assign bus.tx_ready_o     = ~hold_full_q;
  assign bus.rx_overflow_o  = rx_overflow_q;
  assign bus.tx_underflow_o = tx_underflow_q;
  assign bus.busy_o         = ~cs_s;

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - self-checking bench for spi_target with an RX scoreboard.
// Build with SPI_TARGET_ECHO_EN defined to exercise the echo fill byte.
module tb_spi_target;
  localparam int HALF = 4;
`ifdef SPI_TARGET_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  spi_target_if bus ();

  spi_target #(.SyncStages(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] last_rx_m = 8'hFF;
  int         ovf_cnt = 0;
  int         unf_cnt = 0;
  logic       unf_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fill_byte();
    return ECHO ? last_rx_m : 8'hFF;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid_o && bus.rx_ready_i) begin
        if (exp_rx_q.size() == 0) check_eq("rx_unexpected", exp_rx_q.size(), 1);
        else check_eq("rx_data", bus.rx_data_o, exp_rx_q.pop_front());
      end
      if (bus.rx_overflow_o) ovf_cnt++;
      if (bus.tx_underflow_o) begin
        unf_cnt++;
        check_eq("unf_width", unf_prev, 0);
      end
      unf_prev = bus.tx_underflow_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    int n = 0;
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    while (!bus.tx_ready_o && n < 20) begin
      tick(1);
      n++;
    end
    check_eq("tx_ready_wait", n < 20, 1);
    tick(1);
    bus.tx_valid_i = 1'b0;
  endtask

  task automatic cs_low();
    bus.spi_cs_ni = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    bus.spi_cs_ni = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input logic [7:0] exp_read,
                          input bit check_read);
    logic [7:0] rd = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_copi_i = tx[i];
      tick(HALF);
      rd[i] = bus.spi_cipo_o;
      bus.spi_sck_i = 1'b1;
      tick(HALF);
      bus.spi_sck_i = 1'b0;
    end
    if (check_read) check_eq("cipo_read", rd, exp_read);
    if (nbits == 8) last_rx_m = tx;
  endtask

  task automatic accept();
    bus.rx_ready_i = 1'b1;
    tick(1);
    bus.rx_ready_i = 1'b0;
    tick(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_cipo"}, bus.spi_cipo_o, 1);
    check_eq({tag, "_cipo_en"}, bus.spi_cipo_en_o, 0);
    check_eq({tag, "_rx_data"}, bus.rx_data_o, 8'h00);
    check_eq({tag, "_rx_valid"}, bus.rx_valid_o, 0);
    check_eq({tag, "_tx_ready"}, bus.tx_ready_o, 1);
    check_eq({tag, "_ovf"}, bus.rx_overflow_o, 0);
    check_eq({tag, "_unf"}, bus.tx_underflow_o, 0);
    check_eq({tag, "_busy"}, bus.busy_o, 0);
  endtask

  initial begin
    bus.spi_sck_i  = 1'b0;
    bus.spi_cs_ni  = 1'b1;
    bus.spi_copi_i = 1'b0;
    bus.rx_ready_i = 1'b0;
    bus.tx_data_i  = 8'h00;
    bus.tx_valid_i = 1'b0;
    tick(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick(5);

    // Preloaded TX byte, RX held until accepted
    push_tx(8'h3C);
    check_eq("t1_tx_ready_full", bus.tx_ready_o, 0);
    exp_rx_q.push_back(8'hA5);
    unf_cnt = 0;
    cs_low();
    check_eq("t1_tx_ready_start", bus.tx_ready_o, 1);
    check_eq("t1_cipo_en", bus.spi_cipo_en_o, 1);
    check_eq("t1_busy", bus.busy_o, 1);
    check_eq("t1_no_unf", unf_cnt, 0);
    spi_xfer(8'hA5, 8, 8'h3C, 1'b1);
    cs_high();
    tick(20);
    check_eq("t1_rx_valid_held", bus.rx_valid_o, 1);
    check_eq("t1_rx_data_held", bus.rx_data_o, 8'hA5);
    accept();
    check_eq("t1_rx_valid_clr", bus.rx_valid_o, 0);
    check_eq("t1_sb_empty", exp_rx_q.size(), 0);

    // Underflow at frame start
    bus.rx_ready_i = 1'b1;
    unf_cnt = 0;
    exp_rx_q.push_back(8'h00);
    cs_low();
    check_eq("t2_unf_start", unf_cnt, 1);
    spi_xfer(8'h00, 8, fill_byte(), 1'b1);
    cs_high();
    check_eq("t2_sb_empty", exp_rx_q.size(), 0);

    // Overflow on the second byte of a two-byte frame
    bus.rx_ready_i = 1'b0;
    ovf_cnt = 0;
    exp_rx_q.push_back(8'h11);
    cs_low();
    spi_xfer(8'h11, 8, fill_byte(), 1'b1);
    spi_xfer(8'h22, 8, fill_byte(), 1'b1);
    cs_high();
    check_eq("t3_ovf_count", ovf_cnt, 1);
    check_eq("t3_rx_data_kept", bus.rx_data_o, 8'h11);
    accept();
    check_eq("t3_rx_valid_clr", bus.rx_valid_o, 0);
    check_eq("t3_sb_empty", exp_rx_q.size(), 0);

    // Partial frame discarded, then a full frame
    bus.rx_ready_i = 1'b1;
    cs_low();
    spi_xfer(8'hF0, 5, 8'h00, 1'b0);
    cs_high();
    check_eq("t4_cipo_en_gap", bus.spi_cipo_en_o, 0);
    check_eq("t4_rx_valid_gap", bus.rx_valid_o, 0);
    exp_rx_q.push_back(8'h5A);
    cs_low();
    spi_xfer(8'h5A, 8, fill_byte(), 1'b1);
    cs_high();
    check_eq("t4_sb_empty", exp_rx_q.size(), 0);

    // Reset mid-frame with CS held low through release
    cs_low();
    spi_xfer(8'hF0, 4, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick(3);
    rst_n = 1'b1;
    last_rx_m = 8'hFF;
    tick(10);
    check_eq("t5_ignored_frame", bus.spi_cipo_en_o, 0);
    cs_high();
    exp_rx_q.push_back(8'h77);
    cs_low();
    spi_xfer(8'h77, 8, fill_byte(), 1'b1);
    cs_high();
    check_eq("t5_sb_empty", exp_rx_q.size(), 0);

    // Fill byte sequence from a fresh reset (echo build reads FF then C3)
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    last_rx_m = 8'hFF;
    tick(5);
    bus.rx_ready_i = 1'b1;
    exp_rx_q.push_back(8'hC3);
    exp_rx_q.push_back(8'h96);
    cs_low();
    spi_xfer(8'hC3, 8, fill_byte(), 1'b1);
    spi_xfer(8'h96, 8, fill_byte(), 1'b1);
    cs_high();
    check_eq("t6_sb_empty", exp_rx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
